// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
// ST_WAIT exists only when AHB_SRAM_WAIT_EN is defined.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

`ifdef AHB_SRAM_WAIT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM slave.
interface ahb_lite_sram_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic          hmastlock;
  logic [DW-1:0] hwdata;
  logic          hreadyin;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
    output hwdata, hreadyin,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
    input  hwdata, hreadyin,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_strobe_gen.sv
// Maps transfer size and low address bits to a byte-lane strobe and a misalign flag.
// Sizes wider than the bus give an all-zero strobe; the caller flags them separately.
module ahb_lite_strobe_gen
  import ahb_lite_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [2:0]    size,
  input  logic [OW-1:0] addr_lo,
  output logic [NB-1:0] strb,
  output logic          misalign
);
  logic [OW-1:0] lo_mask;
  logic [NB-1:0] base;

  always_comb begin
    lo_mask = '0;
    base    = '0;
    for (int s = 0; s <= OW; s++) begin
      if (size == 3'(s)) begin
        lo_mask = OW'((1 << s) - 1);
        base    = NB'((1 << (1 << s)) - 1);
      end
    end
    misalign = |(addr_lo & lo_mask);
    strb     = base << addr_lo;
  end
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave over a flop-array SRAM with byte strobes and two-cycle ERROR responses.
// Define AHB_SRAM_WAIT_EN to build the WAIT_STATES counter and ST_WAIT; otherwise OKAY is zero-wait.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-OW-1:0] WDEPTH = (AW-OW)'(DEPTH);

  state_t        state_q, state_d;
  logic          act_q, act_d;
  logic          wr_q;
  logic [IW-1:0] idx_q;
  logic [NB-1:0] strb_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-OW-1:0] widx;
  logic [IW-1:0]    idx_in;
  logic [NB-1:0]    strb_in;
  logic             misalign, bad, ready, accept, complete, commit;
  logic [DW-1:0]    wr_word, rd_word;

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  ahb_lite_strobe_gen #(.DW(DW)) u_strobe (
    .size     (bus.hsize),
    .addr_lo  (bus.haddr[OW-1:0]),
    .strb     (strb_in),
    .misalign (misalign)
  );

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  // Own ready gates acceptance too, so a stalled slave never takes a second address.
  assign accept   = bus.hsel & bus.hreadyin & bus.htrans[1] & ready;
  assign widx     = bus.haddr[AW-1:OW];
  assign idx_in   = widx[IW-1:0];
  assign bad      = (widx >= WDEPTH) || (bus.hsize > 3'(OW)) || misalign;
  assign complete = act_q & (state_q == ST_IDLE);
  assign commit   = complete & wr_q;
  assign rd_word  = mem[idx_in];

  always_comb begin
    wr_word = mem[idx_q];
    for (int b = 0; b < NB; b++) begin
      if (strb_q[b]) wr_word[b*8 +: 8] = bus.hwdata[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef AHB_SRAM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (bad) begin
            state_d = ST_ERR1;
          end
`ifdef AHB_SRAM_WAIT_EN
          else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
`endif
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    act_d = act_q;
    if (accept)        act_d = ~bad;
    else if (complete) act_d = 1'b0;
  end

  // A read accepted on the edge that commits a write to the same word sees the new bytes.
  always_comb begin
    rdata_d = '0;
    if (accept && !bad && !bus.hwrite) begin
      rdata_d = (commit && (idx_q == idx_in)) ? wr_word : rd_word;
    end
`ifdef AHB_SRAM_WAIT_EN
    else if (state_q == ST_WAIT) begin
      rdata_d = rdata_q;
    end
`endif
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      act_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wr_q   <= bus.hwrite;
        idx_q  <= idx_in;
        strb_q <= strb_in;
      end
    end
  end

`ifdef AHB_SRAM_WAIT_EN
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Storage is deliberately not reset; a reset coinciding with the commit edge drops the write.
  always_ff @(posedge hclk) begin
    if (commit && !hreset) mem[idx_q] <= wr_word;
  end

  assign bus.hreadyout = ready;
  assign bus.hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = rdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0], 4'(WAIT_STATES)};
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench: a zero-wait slave (a) and a WAIT_STATES=3 slave (b) share one pipelined driver.
module tb_ahb_lite_sram_slave;
  import ahb_lite_pkg::*;

  localparam int WS_B = 3;
`ifdef AHB_SRAM_WAIT_EN
  localparam int WS_B_EFF = WS_B;
`else
  localparam int WS_B_EFF = 0;
`endif

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic        sel, blk, t_write;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_trans;
  logic [2:0]  t_size;

  op_t         op_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [2][256];
  int          checks = 0;
  int          errors = 0;

  ahb_lite_sram_slave_if #(.AW(32), .DW(32)) ia ();
  ahb_lite_sram_slave_if #(.AW(32), .DW(32)) ib ();

  assign ia.hsel      = ~sel;
  assign ib.hsel      = sel;
  assign ia.haddr     = t_addr;
  assign ib.haddr     = t_addr;
  assign ia.htrans    = t_trans;
  assign ib.htrans    = t_trans;
  assign ia.hwrite    = t_write;
  assign ib.hwrite    = t_write;
  assign ia.hsize     = t_size;
  assign ib.hsize     = t_size;
  assign ia.hburst    = 3'b000;
  assign ib.hburst    = 3'b000;
  assign ia.hprot     = 4'b0011;
  assign ib.hprot     = 4'b0011;
  assign ia.hmastlock = 1'b0;
  assign ib.hmastlock = 1'b0;
  assign ia.hwdata    = t_wdata;
  assign ib.hwdata    = t_wdata;
  assign ia.hreadyin  = ia.hreadyout & ~blk;
  assign ib.hreadyin  = ib.hreadyout & ~blk;

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;
  assign o_rdy   = sel ? ib.hreadyout : ia.hreadyout;
  assign o_resp  = sel ? ib.hresp     : ia.hresp;
  assign o_rdata = sel ? ib.hrdata    : ia.hrdata;

  ahb_lite_sram_slave #(.AW(32), .DW(32), .DEPTH(256), .WAIT_STATES(0)) dut_a (
    .hclk(hclk), .hreset(hreset), .bus(ia));
  ahb_lite_sram_slave #(.AW(32), .DW(32), .DEPTH(256), .WAIT_STATES(WS_B)) dut_b (
    .hclk(hclk), .hreset(hreset), .bus(ib));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  task automatic push_op(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    op_t o;
    o.write = w; o.addr = a; o.size = s; o.wdata = d;
    op_q.push_back(o);
  endtask

  // Presents the next queued address phase and records what its data phase must return.
  task automatic drive_addr(output bit act, output logic [31:0] wd);
    op_t         o;
    exp_t        e;
    int          s;
    logic [31:0] idx, w;
    act = 1'b0;
    wd  = '0;
    if (op_q.size() == 0) begin
      t_trans = HTRANS_IDLE;
      t_write = 1'b0;
      return;
    end
    o   = op_q.pop_front();
    s   = sel ? 1 : 0;
    idx = o.addr >> 2;
    e.err   = (idx >= 32'd256) || (o.size > 3'd2) || ((o.addr & ((32'd1 << o.size) - 32'd1)) != 32'd0);
    e.waits = e.err ? 1 : (sel ? WS_B_EFF : 0);
    e.rdata = '0;
    if (!e.err && !o.write) e.rdata = model[s][idx[7:0]];
    if (!e.err && o.write) begin
      w = model[s][idx[7:0]];
      for (int k = 0; k < (1 << o.size); k++) begin
        int lane;
        lane = int'(o.addr[1:0]) + k;
        w[lane*8 +: 8] = o.wdata[lane*8 +: 8];
      end
      model[s][idx[7:0]] = w;
    end
    exp_q.push_back(e);
    t_trans = HTRANS_NONSEQ;
    t_addr  = o.addr;
    t_write = o.write;
    t_size  = o.size;
    act     = 1'b1;
    wd      = o.wdata;
  endtask

  task automatic run_ops();
    bit          a_act, d_act, adv, lowresp_ok;
    logic [31:0] a_wd;
    int          lowc, guard;
    exp_t        e;
    d_act = 1'b0; lowc = 0; guard = 0; lowresp_ok = 1'b1;
    @(posedge hclk); #1;
    drive_addr(a_act, a_wd);
    while ((a_act || d_act) && guard < 400) begin
      guard++;
      @(negedge hclk);
      adv = o_rdy;
      if (d_act) begin
        if (!o_rdy) begin
          lowc++;
          if (o_resp !== exp_q[0].err) lowresp_ok = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check_eq("data_phase_waits", 32'(lowc), 32'(e.waits));
          check_eq("hresp", 32'(o_resp), 32'(e.err));
          check_eq("hrdata", o_rdata, e.rdata);
          check_eq("hresp_while_stalled", 32'(lowresp_ok), 32'd1);
          d_act = 1'b0; lowc = 0; lowresp_ok = 1'b1;
        end
      end else begin
        check_eq("idle_ready_resp", {30'd0, o_rdy, o_resp}, 32'd2);
        check_eq("idle_rdata", o_rdata, 32'd0);
      end
      @(posedge hclk); #1;
      if (adv) begin
        d_act   = a_act;
        t_wdata = a_wd;
        drive_addr(a_act, a_wd);
      end
    end
    if (guard >= 400) check_eq("run_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    sel = 1'b0; blk = 1'b0; t_addr = '0; t_trans = HTRANS_IDLE;
    t_write = 1'b0; t_size = HSIZE_WORD; t_wdata = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) model[s][i] = '0;

    #12;
    check_eq("rst_a_ready", 32'(ia.hreadyout), 32'd1);
    check_eq("rst_a_resp", 32'(ia.hresp), 32'd0);
    check_eq("rst_a_rdata", ia.hrdata, 32'd0);
    check_eq("rst_b_ready", 32'(ib.hreadyout), 32'd1);
    check_eq("rst_b_resp", 32'(ib.hresp), 32'd0);
    check_eq("rst_b_rdata", ib.hrdata, 32'd0);
    @(negedge hclk);
    hreset = 1'b0;

    // Write/read, byte and halfword merges, read-after-write, errors on the zero-wait slave.
    sel = 1'b0;
    push_op(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    push_op(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    run_ops();
    push_op(1'b1, 32'h20, HSIZE_WORD, 32'h1122_3344);
    push_op(1'b1, 32'h23, HSIZE_BYTE, 32'hAA00_0000);
    push_op(1'b0, 32'h20, HSIZE_WORD, 32'h0);
    push_op(1'b1, 32'h24, HSIZE_WORD, 32'h5566_7788);
    push_op(1'b1, 32'h26, HSIZE_HALF, 32'hBEEF_0000);
    push_op(1'b0, 32'h24, HSIZE_WORD, 32'h0);
    push_op(1'b1, 32'h40, HSIZE_WORD, 32'h5);
    push_op(1'b0, 32'h40, HSIZE_WORD, 32'h0);
    run_ops();

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      push_op(1'b1, 32'h00, HSIZE_WORD, 32'h0102_0304);
      push_op(1'b1, 32'h400, HSIZE_WORD, 32'hFFFF_FFFF);
      push_op(1'b1, 32'h01, HSIZE_HALF, 32'hFFFF_FFFF);
      push_op(1'b0, 32'h08, HSIZE_DWORD, 32'h0);
      push_op(1'b0, 32'h00, HSIZE_WORD, 32'h0);
      run_ops();
    end

    // Address phase presented while the bus hready is low must be ignored.
    sel = 1'b0;
    @(posedge hclk); #1;
    blk = 1'b1;
    t_trans = HTRANS_NONSEQ; t_addr = 32'h00; t_write = 1'b1; t_size = HSIZE_WORD;
    @(posedge hclk); #1;
    t_trans = HTRANS_IDLE; t_wdata = 32'hFFFF_FFFF; blk = 1'b0;
    @(negedge hclk);
    check_eq("blocked_ready", 32'(ia.hreadyout), 32'd1);
    check_eq("blocked_resp", 32'(ia.hresp), 32'd0);
    push_op(1'b0, 32'h00, HSIZE_WORD, 32'h0);
    run_ops();

    // Wait-state slave: single write/read and back-to-back read-after-write.
    sel = 1'b1;
    push_op(1'b1, 32'h30, HSIZE_WORD, 32'hCAFE_F00D);
    run_ops();
    push_op(1'b0, 32'h30, HSIZE_WORD, 32'h0);
    run_ops();
    push_op(1'b1, 32'h40, HSIZE_WORD, 32'h5);
    push_op(1'b0, 32'h40, HSIZE_WORD, 32'h0);
    run_ops();

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 16; i++) push_op(1'b1, 32'h80 + 32'(i) * 4, HSIZE_WORD, $urandom);
      for (int n = 0; n < 40; n++) begin
        o.write = 1'($urandom_range(0, 1));
        o.size  = 3'($urandom_range(0, 2));
        o.addr  = 32'h80 + 32'($urandom_range(0, 15)) * 4
                + (32'($urandom_range(0, 3)) & ~((32'd1 << o.size) - 32'd1));
        o.wdata = $urandom;
        case ($urandom_range(0, 9))
          0: o.addr = o.addr | 32'h400;
          1: o.size = HSIZE_DWORD;
          2: if (o.size != HSIZE_BYTE) o.addr[0] = 1'b1;
          default: ;
        endcase
        op_q.push_back(o);
      end
      run_ops();
    end

    // Reset during the data phase of a write on the wait-state slave.
    sel = 1'b1;
    push_op(1'b1, 32'h60, HSIZE_WORD, 32'h1234_5678);
    run_ops();
    @(posedge hclk); #1;
    t_trans = HTRANS_NONSEQ; t_addr = 32'h60; t_write = 1'b1; t_size = HSIZE_WORD;
    @(posedge hclk); #1;
    t_trans = HTRANS_IDLE; t_write = 1'b0; t_wdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check_eq("pre_reset_ready", 32'(ib.hreadyout), (WS_B_EFF > 0) ? 32'd0 : 32'd1);
    hreset = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(ib.hreadyout), 32'd1);
    check_eq("midrst_resp", 32'(ib.hresp), 32'd0);
    check_eq("midrst_rdata", ib.hrdata, 32'd0);
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
    push_op(1'b0, 32'h60, HSIZE_WORD, 32'h0);
    run_ops();

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

Parametrised AHB-Lite slave with a flop-array memory. It implements programmable wait states, byte/halfword/word write strobes and two-cycle ERROR responses. The block is the DUT-side counterpart of the VIP's `dut_if` driver/monitor clocking blocks, and it replaces the fixed-width zero-wait slave used in earlier benches.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; legal values are 32 or 64.
- `DEPTH`, 256: number of DW-wide words.
- `WAIT_STATES`, 0: extra data-phase cycles per OKAY transfer, range 0..15.

Ports:
- `hclk`  in  1: clock. One clock only.
- `hreset`  in  1: reset, asynchronous, active-high.
- `hsel`  in  1: slave select.
- `haddr`  in  AW: byte address.
- `htrans`  in  2: IDLE, BUSY, NONSEQ or SEQ.
- `hwrite`  in  1: 1 = write.
- `hsize`  in  3: transfer size.
- `hburst`  in  3: burst type. Ignored; each beat is handled independently.
- `hprot`  in  4: protection. Ignored.
- `hmastlock`  in  1: locked transfer. Ignored.
- `hwdata`  in  DW: write data, valid in the data phase.
- `hreadyin`  in  1: bus-level hready from the interconnect.
- `hreadyout`  out  1: slave ready.
- `hresp`  out  1: 0 = OKAY, 1 = ERROR.
- `hrdata`  out  DW: read data.

## Operation
- **Address phase accepted** when `hsel & hreadyin & htrans[1]` at a rising edge. On acceptance the block registers `haddr`, `hwrite` and `hsize`.
- **IDLE/BUSY or unselected:** zero-wait OKAY response.
- **Error check at acceptance.** The transfer is an error if any of these holds:
  - word index `haddr >> log2(DW/8)` >= DEPTH;
  - `hsize` > log2(DW/8);
  - `haddr` is misaligned to `hsize`.
- **FSM states:** `ST_IDLE`, `ST_WAIT`, `ST_ERR1`, `ST_ERR2`.
  - `ST_IDLE`: `hreadyout`=1, `hresp`=0.
  - On a good accept: if WAIT_STATES>0, go to `ST_WAIT` and load the counter with WAIT_STATES-1. Otherwise complete in the next cycle.
  - `ST_WAIT`: `hreadyout`=0 and the counter decrements. At 0, the next cycle is the completing cycle with `hreadyout`=1.
  - On a bad accept: go to `ST_ERR1` (`hreadyout`=0, `hresp`=1), then `ST_ERR2` (`hreadyout`=1, `hresp`=1), then `ST_IDLE`. A new address accepted during `ST_ERR2` is processed normally.
- **Write commit** happens at the edge ending the completing data-phase cycle. `hwdata` bytes are gated by the strobe derived from the registered `hsize` and the low address bits. Errored writes never modify memory.
- **Read data:** `hrdata` = mem[registered word index] during a read data phase. It is 0 otherwise, including during ERROR responses.
- **Back-to-back transfers:** the completing cycle of transfer N may accept transfer N+1.
- **Read-after-write to the same address:** returns the newly written data with no stall.
- **Reset mid-transfer:** the pending transfer is dropped, no memory write occurs and the FSM returns to `ST_IDLE`. Memory contents are not reset.

## Timing
- Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0, FSM=`ST_IDLE`, wait counter=0.
- OKAY latency is 1+WAIT_STATES data-phase cycles.
- ERROR latency is always 2 cycles, independent of WAIT_STATES.
- `hrdata`, `hreadyout` and `hresp` are driven from registered state only. There is no combinational path from `haddr` or `htrans` to any output.
- Transfers accepted while `hreadyin`=0 are ignored.

## Configuration
- Macro `AHB_SRAM_WAIT_EN`.
  - **Defined:** the WAIT_STATES parameter, the wait counter and `ST_WAIT` are built.
  - **Undefined:** there is no counter and no `ST_WAIT`. Every OKAY transfer is zero-wait, regardless of WAIT_STATES.

## Structure
- Package `ahb_lite_pkg` holds:
  - the HTRANS constants (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - the HSIZE constants;
  - the HRESP constants;
  - the FSM state enum.
- Sub-module `ahb_lite_strobe_gen` maps (`hsize`, `haddr` low bits, DW) to a DW/8 byte-strobe vector and a misalign flag.

## Test plan
All scenarios use DW=32 and DEPTH=256.
1. Reset, then NONSEQ write word 0xDEADBEEF to 0x10, then read 0x10 with WAIT_STATES=0: read returns 0xDEADBEEF; `hreadyout` never drops.
2. WAIT_STATES=3, single read: `hreadyout` is low for exactly 3 cycles, then high with valid `hrdata` and OKAY.
3. Byte write 0xAA to 0x13 over a stored 0x11223344, then word read: returns 0xAA223344.
4. Write to 0x400 (word index 256), then a halfword write to 0x01: each gives ERROR for 2 cycles (`hreadyout` 0 then 1, `hresp`=1) and memory is unchanged.
5. Back-to-back NONSEQ write 0x5 then read of the same address: read data is 0x5 with no extra stall.
6. `hreset` asserted during `ST_WAIT` of a write: outputs return to reset values immediately and the target word keeps its old value.
